// File: rtl/memory_control_arb.sv
// Single-port memory arbiter: data and instruction requesters share one RAM port.
// Data has fixed priority, and a grant is held until completion, error, timeout or withdrawal.
module memory_control_arb #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ccwait,
   output logic        ccinv,
   output logic [31:0] ccsnoopaddr,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

   state_t     state, state_next;
   ramstate_t  rs;
   logic [7:0] cnt, cnt_next;
   logic       err_set;

   assign rs          = ramstate_t'(ramstate);
   assign ccwait      = 1'b0;
   assign ccinv       = 1'b0;
   assign ccsnoopaddr = 32'h0;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = 8'h0;
      err_set    = 1'b0;
      iwait      = 1'b1;
      dwait      = 1'b1;
      iload      = 32'h0;
      dload      = 32'h0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = 32'h0;
      ramstore   = 32'h0;

      // While reset is high the block looks idle, even though the state register is not yet cleared.
      if (!RST) begin
         case (state)
            IDLE: begin
               if (dREN || dWEN)
                  state_next = DGNT;
               else if (iREN)
                  state_next = IGNT;
            end

            DGNT: begin
               if (!dREN && !dWEN) begin
                  state_next = IDLE;
               end else begin
                  ramaddr  = daddr;
                  ramstore = dstore;
                  ramWEN   = dWEN;
                  ramREN   = dREN & ~dWEN;
                  if (rs == ACCESS) begin
                     dwait      = 1'b0;
                     dload      = ramload;
                     state_next = IDLE;
                  end else if (rs == ERROR) begin
                     dwait      = 1'b0;
                     dload      = ramload;
                     err_set    = 1'b1;
                     state_next = IDLE;
                  end else if (cnt == TIMEOUT) begin
                     dwait      = 1'b0;
                     err_set    = 1'b1;
                     state_next = IDLE;
                  end else begin
                     cnt_next = cnt + 8'h1;
                  end
               end
            end

            IGNT: begin
               if (!iREN) begin
                  state_next = IDLE;
               end else begin
                  ramaddr = iaddr;
                  ramREN  = 1'b1;
                  if (rs == ACCESS) begin
                     iwait      = 1'b0;
                     iload      = ramload;
                     state_next = IDLE;
                  end else if (rs == ERROR) begin
                     iwait      = 1'b0;
                     iload      = ramload;
                     err_set    = 1'b1;
                     state_next = IDLE;
                  end else if (cnt == TIMEOUT) begin
                     iwait      = 1'b0;
                     err_set    = 1'b1;
                     state_next = IDLE;
                  end else begin
                     cnt_next = cnt + 8'h1;
                  end
               end
            end

            default: state_next = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= 8'h0;
         bus_err <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (err_set)
            bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_memory_control_arb.sv
// Self-checking bench for memory_control_arb: scripted RAM responses, and a queue scoreboard
// for expected load data. Two instances run side by side: one with the default timeout and one with TIMEOUT=4.
module tb_memory_control_arb;

   localparam logic [1:0] RS_FREE   = 2'd0;
   localparam logic [1:0] RS_BUSY   = 2'd1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   logic        CLK = 1'b0;
   logic        RST, iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;

   logic        iwait, dwait, ccwait, ccinv, ramREN, ramWEN, bus_err;
   logic [31:0] iload, dload, ccsnoopaddr, ramaddr, ramstore;
   logic        iwait_t, dwait_t, ccwait_t, ccinv_t, ramREN_t, ramWEN_t, bus_err_t;
   logic [31:0] iload_t, dload_t, ccsnoopaddr_t, ramaddr_t, ramstore_t;

   always #5 CLK = ~CLK;

   memory_control_arb u_dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
   );

   memory_control_arb #(.TIMEOUT(8'd4)) u_dut_to (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait_t), .iload(iload_t),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait_t), .dload(dload_t),
      .ccwait(ccwait_t), .ccinv(ccinv_t), .ccsnoopaddr(ccsnoopaddr_t),
      .ramREN(ramREN_t), .ramWEN(ramWEN_t), .ramaddr(ramaddr_t), .ramstore(ramstore_t),
      .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err_t)
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      logic [7:0] got;
      RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
      iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = RS_FREE;
      tick; tick;
      @(negedge CLK);
      got = {iwait, dwait, ramREN, ramWEN, bus_err, ccwait, ccinv, |ccsnoopaddr};
      total++;
      if (got !== 8'b1100_0000) begin
         bad++; $display("FAIL reset_outputs got=%b exp=11000000", got);
      end
      got = {iwait_t, dwait_t, ramREN_t, ramWEN_t, bus_err_t, ccwait_t, ccinv_t, |ccsnoopaddr_t};
      total++;
      if (got !== 8'b1100_0000) begin
         bad++; $display("FAIL reset_outputs_to got=%b exp=11000000", got);
      end
      tick;
      RST = 1'b0; iREN = 1'b0;
   endtask

   task automatic test_fetch;
      exp_t e;
      iREN = 1'b1; iaddr = 32'h40; ramstate = RS_FREE; ramload = 32'h0;
      @(negedge CLK);
      total++;
      if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
         bad++; $display("FAIL fetch_idle got=%b exp=1100", {iwait, dwait, ramREN, ramWEN});
      end
      sbq.push_back({1'b0, 32'h8C220004});
      tick;
      ramstate = RS_ACCESS; ramload = 32'h8C220004;
      @(negedge CLK);
      total++;
      if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
         bad++; $display("FAIL fetch_strobe got=%b/%b/%h exp=1/0/00000040", ramREN, ramWEN, ramaddr);
      end
      total++;
      if ({iwait, dwait} !== 2'b01) begin
         bad++; $display("FAIL fetch_wait got=%b exp=01", {iwait, dwait});
      end else begin
         e = sbq.pop_front();
         total++;
         if (e.is_d || iload !== e.data) begin
            bad++; $display("FAIL fetch_iload got=%h exp=%h", iload, e.data);
         end
      end
      tick;
      iREN = 1'b0; ramstate = RS_FREE; ramload = 32'h12345678;
      @(negedge CLK);
      total++;
      if ({iwait, ramREN, iload, dload} !== {2'b10, 64'h0}) begin
         bad++; $display("FAIL fetch_after got=%b%b/%h/%h exp=10/0/0", iwait, ramREN, iload, dload);
      end
   endtask

   task automatic test_contention;
      exp_t e;
      iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
      ramstate = RS_FREE; ramload = 32'h0;
      sbq.push_back({1'b1, 32'hCAFE0001});
      for (int c = 1; c <= 2; c++) begin
         tick;
         ramstate = RS_BUSY;
         @(negedge CLK);
         total++;
         if ({ramWEN, ramREN, ramaddr, ramstore, dwait, iwait} !== {2'b10, 32'h100, 32'hDEADBEEF, 2'b11}) begin
            bad++; $display("FAIL contention_busy%0d got=%b%b/%h/%h/%b%b exp=10/100/deadbeef/11",
                            c, ramWEN, ramREN, ramaddr, ramstore, dwait, iwait);
         end
      end
      tick;
      ramstate = RS_ACCESS; ramload = 32'hCAFE0001;
      @(negedge CLK);
      total++;
      if ({dwait, iwait} !== 2'b01) begin
         bad++; $display("FAIL contention_dwait got=%b exp=01", {dwait, iwait});
      end else begin
         e = sbq.pop_front();
         total++;
         if (!e.is_d || dload !== e.data) begin
            bad++; $display("FAIL contention_dload got=%h exp=%h", dload, e.data);
         end
      end
      tick;
      dWEN = 1'b0; ramstate = RS_FREE;
      @(negedge CLK);
      total++;
      if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
         bad++; $display("FAIL contention_idle got=%b exp=0011", {ramREN, ramWEN, iwait, dwait});
      end
      sbq.push_back({1'b0, 32'h11112222});
      tick;
      ramstate = RS_ACCESS; ramload = 32'h11112222;
      @(negedge CLK);
      total++;
      if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h80, 1'b0}) begin
         bad++; $display("FAIL contention_fetch got=%b/%h/%b exp=1/00000080/0", ramREN, ramaddr, iwait);
      end else begin
         e = sbq.pop_front();
         total++;
         if (e.is_d || iload !== e.data) begin
            bad++; $display("FAIL contention_iload got=%h exp=%h", iload, e.data);
         end
      end
      tick;
      iREN = 1'b0; ramstate = RS_FREE;
   endtask

   task automatic test_both_strobes;
      exp_t e;
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h77; ramstate = RS_FREE;
      sbq.push_back({1'b1, 32'h5});
      tick;
      ramstate = RS_BUSY;
      @(negedge CLK);
      total++;
      if ({ramREN, ramWEN, ramstore} !== {2'b01, 32'h77}) begin
         bad++; $display("FAIL both_strobes got=%b%b/%h exp=01/00000077", ramREN, ramWEN, ramstore);
      end
      tick;
      ramstate = RS_ACCESS; ramload = 32'h5;
      @(negedge CLK);
      total++;
      if (dwait !== 1'b0) begin
         bad++; $display("FAIL both_dwait got=%b exp=0", dwait);
      end else begin
         e = sbq.pop_front();
         total++;
         if (!e.is_d || dload !== e.data) begin
            bad++; $display("FAIL both_dload got=%h exp=%h", dload, e.data);
         end
      end
      tick;
      dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
   endtask

   task automatic test_back_to_back;
      exp_t e;
      dREN = 1'b1; daddr = 32'h600; ramstate = RS_FREE;
      sbq.push_back({1'b1, 32'hA1});
      tick;
      ramstate = RS_ACCESS; ramload = 32'hA1;
      @(negedge CLK);
      total++;
      if ({ramREN, ramWEN, ramaddr, dwait} !== {2'b10, 32'h600, 1'b0}) begin
         bad++; $display("FAIL b2b_first got=%b%b/%h/%b exp=10/600/0", ramREN, ramWEN, ramaddr, dwait);
      end else begin
         e = sbq.pop_front();
         total++;
         if (!e.is_d || dload !== e.data) begin
            bad++; $display("FAIL b2b_dload1 got=%h exp=%h", dload, e.data);
         end
      end
      tick;
      daddr = 32'h604; ramstate = RS_FREE;
      @(negedge CLK);
      total++;
      if ({dwait, ramREN, dload} !== {2'b10, 32'h0}) begin
         bad++; $display("FAIL b2b_gap got=%b%b/%h exp=10/0", dwait, ramREN, dload);
      end
      sbq.push_back({1'b1, 32'hA2});
      tick;
      ramstate = RS_ACCESS; ramload = 32'hA2;
      @(negedge CLK);
      total++;
      if ({ramaddr, dwait} !== {32'h604, 1'b0}) begin
         bad++; $display("FAIL b2b_second got=%h/%b exp=604/0", ramaddr, dwait);
      end else begin
         e = sbq.pop_front();
         total++;
         if (!e.is_d || dload !== e.data) begin
            bad++; $display("FAIL b2b_dload2 got=%h exp=%h", dload, e.data);
         end
      end
      tick;
      dREN = 1'b0; ramstate = RS_FREE;
   endtask

   task automatic test_error;
      exp_t e;
      dREN = 1'b1; daddr = 32'h300; ramstate = RS_FREE;
      sbq.push_back({1'b1, 32'hBAD0BAD0});
      tick;
      ramstate = RS_ERROR; ramload = 32'hBAD0BAD0;
      @(negedge CLK);
      total++;
      if (dwait !== 1'b0) begin
         bad++; $display("FAIL error_dwait got=%b exp=0", dwait);
      end else begin
         e = sbq.pop_front();
         total++;
         if (!e.is_d || dload !== e.data) begin
            bad++; $display("FAIL error_dload got=%h exp=%h", dload, e.data);
         end
      end
      tick;
      dREN = 1'b0; ramstate = RS_FREE;
      @(negedge CLK);
      total++;
      if ({bus_err, bus_err_t, dwait} !== 3'b111) begin
         bad++; $display("FAIL error_flag got=%b exp=111", {bus_err, bus_err_t, dwait});
      end
      tick;
      @(negedge CLK);
      total++;
      if (bus_err !== 1'b1) begin
         bad++; $display("FAIL error_sticky got=%b exp=1", bus_err);
      end
   endtask

   task automatic test_withdraw;
      dREN = 1'b1; daddr = 32'h700; ramstate = RS_FREE;
      tick;
      ramstate = RS_BUSY;
      @(negedge CLK);
      total++;
      if ({ramREN, dwait} !== 2'b11) begin
         bad++; $display("FAIL withdraw_grant got=%b exp=11", {ramREN, dwait});
      end
      tick;
      dREN = 1'b0;
      @(negedge CLK);
      total++;
      if ({ramREN, ramWEN, dwait} !== 3'b001) begin
         bad++; $display("FAIL withdraw_drop got=%b exp=001", {ramREN, ramWEN, dwait});
      end
      tick;
      ramstate = RS_ACCESS;
      @(negedge CLK);
      total++;
      if ({ramREN, dwait, bus_err} !== 3'b010) begin
         bad++; $display("FAIL withdraw_idle got=%b exp=010", {ramREN, dwait, bus_err});
      end
      tick;
      ramstate = RS_FREE;
   endtask

   task automatic test_timeout;
      exp_t e;
      int   early;
      dREN = 1'b1; daddr = 32'h400; ramstate = RS_BUSY; ramload = 32'hFFFFFFFF;
      sbq.push_back({1'b1, 32'h0});
      for (int k = 1; k <= 4; k++) begin
         tick;
         @(negedge CLK);
         total++;
         if (dwait_t !== 1'b1) begin
            bad++; $display("FAIL timeout4_early cycle=%0d got=%b exp=1", k, dwait_t);
         end
      end
      tick;
      @(negedge CLK);
      total++;
      if ({dwait_t, dwait} !== 2'b01) begin
         bad++; $display("FAIL timeout4_fire got=%b exp=01", {dwait_t, dwait});
      end else begin
         e = sbq.pop_front();
         total++;
         if (!e.is_d || dload_t !== e.data) begin
            bad++; $display("FAIL timeout4_dload got=%h exp=%h", dload_t, e.data);
         end
      end
      tick;
      @(negedge CLK);
      total++;
      if ({bus_err_t, bus_err} !== 2'b10) begin
         bad++; $display("FAIL timeout4_flag got=%b exp=10", {bus_err_t, bus_err});
      end
      early = 0;
      for (int k = 7; k <= 255; k++) begin
         tick;
         @(negedge CLK);
         if (dwait !== 1'b1) early++;
      end
      total++;
      if (early != 0) begin
         bad++; $display("FAIL timeout255_early got=%0d exp=0", early);
      end
      sbq.push_back({1'b1, 32'h0});
      tick;
      @(negedge CLK);
      total++;
      if (dwait !== 1'b0) begin
         bad++; $display("FAIL timeout255_fire got=%b exp=0", dwait);
      end else begin
         e = sbq.pop_front();
         total++;
         if (!e.is_d || dload !== e.data) begin
            bad++; $display("FAIL timeout255_dload got=%h exp=%h", dload, e.data);
         end
      end
      tick;
      dREN = 1'b0; ramstate = RS_FREE;
      @(negedge CLK);
      total++;
      if (bus_err !== 1'b1) begin
         bad++; $display("FAIL timeout255_flag got=%b exp=1", bus_err);
      end
      tick;
   endtask

   task automatic test_rst_mid;
      iREN = 1'b1; iaddr = 32'h500; ramstate = RS_FREE;
      tick;
      ramstate = RS_BUSY;
      @(negedge CLK);
      total++;
      if ({ramREN, iwait} !== 2'b11) begin
         bad++; $display("FAIL rstmid_grant got=%b exp=11", {ramREN, iwait});
      end
      tick;
      RST = 1'b1;
      @(negedge CLK);
      total++;
      if ({iwait, dwait} !== 2'b11) begin
         bad++; $display("FAIL rstmid_waits got=%b exp=11", {iwait, dwait});
      end
      tick;
      RST = 1'b0;
      @(negedge CLK);
      total++;
      if ({ramREN, ramWEN, iwait, bus_err} !== 4'b0010) begin
         bad++; $display("FAIL rstmid_idle got=%b exp=0010", {ramREN, ramWEN, iwait, bus_err});
      end
      tick;
      @(negedge CLK);
      total++;
      if ({ramREN, ramaddr} !== {1'b1, 32'h500}) begin
         bad++; $display("FAIL rstmid_regrant got=%b/%h exp=1/500", ramREN, ramaddr);
      end
      tick;
      iREN = 1'b0;
      @(negedge CLK);
      total++;
      if ({ramREN, iwait} !== 2'b01) begin
         bad++; $display("FAIL rstmid_withdraw got=%b exp=01", {ramREN, iwait});
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_contention;
      test_both_strobes;
      test_back_to_back;
      test_error;
      test_reset;
      test_withdraw;
      test_timeout;
      test_rst_mid;
      total++;
      if (sbq.size() != 0) begin
         bad++; $display("FAIL scoreboard_left got=%0d exp=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_control_arb.md
# memory_control_arb

Responder end of the cache/memory handshake. Arbitrates the instruction-fetch port (iREN/iaddr) and the data port (dREN/dWEN/daddr/dstore) onto a single shared RAM port, returns iwait/iload and dwait/dload to the requesters, and holds the coherence inputs quiet for the single-core build. It sits between the datapath's cache ports and the RAM model.

## Interface
- TIMEOUT, 255: cycles a granted access may wait for ramstate ACCESS before being aborted; 8-bit counter.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iwait  out  1  high = stall the fetch; low for exactly the completing cycle.
- iload  out  32  instruction data; valid when iwait low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins if dREN is also high.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  high = stall the data access; low for exactly the completing cycle.
- dload  out  32  read data; valid when dwait low.
- ccwait, ccinv  out  1  each  tied 0.
- ccsnoopaddr  out  32  tied 0.
- ramREN, ramWEN  out  1  each  RAM strobes; never both high.
- ramaddr, ramstore  out  32  each  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- bus_err  out  1  sticky error flag.

## Operation
- States: IDLE, DGNT, IGNT. Reset -> IDLE, timeout counter 0, bus_err 0.
- IDLE: RAM strobes 0, ramaddr/ramstore 0, iwait=dwait=1. If dREN|dWEN -> DGNT. Else if iREN -> IGNT. Data has fixed priority.
- DGNT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. iwait=1.
  - ramstate==ACCESS: dwait=0 and dload=ramload in the same cycle; next state IDLE.
  - ramstate==ERROR: dwait=0, dload=ramload, set bus_err, next state IDLE.
  - Counter reaches TIMEOUT: dwait=0, dload=32'h0, set bus_err, next state IDLE.
  - dREN and dWEN both drop, with no completion: strobes 0 that cycle, dwait=1, next state IDLE. The access is abandoned.
  - Otherwise stay in DGNT and increment the counter.
- IGNT: the same rules using iaddr and ramREN=iREN. ramWEN=0, ramstore=0. iwait and iload complete the access; dwait=1. A dREN or dWEN arriving mid-grant does not preempt the access.
- The grant is never switched before completion, error, timeout or withdrawal.
- The counter clears on every entry to IDLE.
- dload and iload are 0 except in their completing cycle.
- bus_err clears only on RST.

## Timing
- Requests are sampled in IDLE. The grant state starts the next cycle, so there is one arbitration cycle of overhead.
- Minimum latency from a request in IDLE to wait low is 1 cycle, when the RAM returns ACCESS in the first grant cycle.
- After completion there is one mandatory IDLE cycle. Back-to-back accesses therefore take at least 2 cycles each.
- If both ports request in IDLE at cycle t: data completes first. The fetch is granted at the earliest at t+3.
- RST asserted mid-grant: at the next edge go to IDLE and drop the strobes. iwait=dwait=1 while RST is high. The partial RAM access is not retried.
- Timeout fires on the cycle the counter equals TIMEOUT, i.e. the (TIMEOUT+1)th grant cycle.

## Test plan
- Reset: hold RST 2 cycles with iREN=1 -> iwait=dwait=1, ramREN=ramWEN=0, bus_err=0, cc* = 0.
- Fetch: iREN=1, iaddr=0x40, RAM ACCESS on the first grant cycle, ramload=0x8C220004 -> ramREN=1, ramaddr=0x40 at cycle 1; iwait=0 and iload=0x8C220004 at cycle 1 only.
- Contention: iREN=1 and dWEN=1 with daddr=0x100, dstore=0xDEADBEEF, RAM 2 BUSY cycles then ACCESS -> ramWEN=1 and ramaddr=0x100 first; dwait low at cycle 3; the fetch is granted at cycle 5.
- Both strobes: dREN=dWEN=1 -> ramWEN=1, ramREN=0.
- Error/timeout: ramstate=ERROR during a read -> dwait low that cycle, bus_err=1 and held. Separately, TIMEOUT=4 with ramstate stuck BUSY -> dwait low on grant cycle 5, dload=0, bus_err=1.
- Withdrawal and reset: drop dREN during BUSY -> IDLE next cycle with no dwait pulse. Assert RST mid-IGNT -> IDLE, strobes 0 at the next edge.
